dram_ctrl: RTL and testbench

- Memory-side controller directly downstream of the data cache; consumes its refill/writeback and uncached beats.
- Serves one sized access at a time from an on-chip word-organised RAM with a fixed, parameterised access latency.
- Reports progress on a 2-bit state bus; 2'b00 signals completion of the current beat. Read data is valid on the completion cycle.

---
 rtl/dram_ctrl_if.sv | 24 ++
 rtl/dram_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_dram_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/dram_ctrl_if.sv
// Request/response bundle between the data cache and dram_ctrl.
// The cache drives the request side (master); the controller answers
// with read data and a 2-bit progress code (slave).
interface dram_ctrl_if #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64
);
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] din;
   logic [2:0]            rd_ctrl;
   logic [2:0]            wr_ctrl;
   logic [DATA_WIDTH-1:0] dout;
   logic [1:0]            state;

   modport master (
      output addr, din, rd_ctrl, wr_ctrl,
      input  dout, state
   );

   modport slave (
      input  addr, din, rd_ctrl, wr_ctrl,
      output dout, state
   );
endinterface

// File: rtl/dram_ctrl.sv
// Memory-side controller behind the data cache. Serves one sized beat at
// a time from a word-organised on-chip RAM with a fixed access latency.
// Progress is reported on a 2-bit code: 00 done/ready, 01 reading,
// 10 writing, 11 error (shown on the done cycle of a rejected beat).
module dram_ctrl #(
   parameter int                    ADDR_WIDTH = 64,
   parameter int                    DATA_WIDTH = 64,
   parameter int                    MEM_WORDS  = 4096,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 64'h0000_0000_8000_0000,
   parameter int                    LATENCY    = 3
) (
   input  logic       clk,
   input  logic       rst,
   dram_ctrl_if.slave bus
);

   localparam int IDX_W = $clog2(MEM_WORDS);
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'(LATENCY - 1);
   // One past the last valid byte; computed at full address width so that
   // addresses far above the RAM window never alias back into it.
   localparam logic [ADDR_WIDTH-1:0] END_ADDR = BASE_ADDR + (ADDR_WIDTH'(MEM_WORDS) << 3);

   localparam logic [1:0] CODE_OK  = 2'b00;
   localparam logic [1:0] CODE_RD  = 2'b01;
   localparam logic [1:0] CODE_WR  = 2'b10;
   localparam logic [1:0] CODE_ERR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_DONE   = 2'b10
   } fsm_t;

   // Byte count of a read opcode (0 for none).
   function automatic logic [3:0] rd_size(input logic [2:0] code);
      logic [3:0] sz;
      case (code)
         3'b001, 3'b010: sz = 4'd1;
         3'b011, 3'b100: sz = 4'd2;
         3'b101, 3'b111: sz = 4'd4;
         3'b110:         sz = 4'd8;
         default:        sz = 4'd0;
      endcase
      return sz;
   endfunction

   // Byte count of a write opcode (0 for none or illegal).
   function automatic logic [3:0] wr_size(input logic [2:0] code);
      logic [3:0] sz;
      case (code)
         3'b001:  sz = 4'd1;
         3'b010:  sz = 4'd2;
         3'b011:  sz = 4'd4;
         3'b100:  sz = 4'd8;
         default: sz = 4'd0;
      endcase
      return sz;
   endfunction

   // Bit mask covering `size` bytes starting at byte lane `off`.
   function automatic logic [63:0] lane_mask(input logic [3:0] size, input logic [2:0] off);
      logic [63:0] m;
      case (size)
         4'd1:    m = 64'h0000_0000_0000_00FF;
         4'd2:    m = 64'h0000_0000_0000_FFFF;
         4'd4:    m = 64'h0000_0000_FFFF_FFFF;
         4'd8:    m = 64'hFFFF_FFFF_FFFF_FFFF;
         default: m = 64'h0000_0000_0000_0000;
      endcase
      return m << {off, 3'b000};
   endfunction

   // Pick the addressed bytes out of a RAM word and sign/zero extend them.
   function automatic logic [63:0] fmt_read(input logic [63:0] word, input logic [2:0] off,
                                            input logic [2:0] code);
      logic [63:0] sh;
      logic [63:0] r;
      sh = word >> {off, 3'b000};
      case (code)
         3'b001:  r = {{56{sh[7]}}, sh[7:0]};
         3'b010:  r = {56'd0, sh[7:0]};
         3'b011:  r = {{48{sh[15]}}, sh[15:0]};
         3'b100:  r = {48'd0, sh[15:0]};
         3'b101:  r = {{32{sh[31]}}, sh[31:0]};
         3'b111:  r = {32'd0, sh[31:0]};
         3'b110:  r = sh;
         default: r = 64'd0;
      endcase
      return r;
   endfunction

   logic [63:0]           mem_r [MEM_WORDS];

   fsm_t                  fsm_r;
   logic [CNT_W-1:0]      cnt_r;
   logic [ADDR_WIDTH-1:0] addr_r;
   logic [DATA_WIDTH-1:0] din_r;
   logic [2:0]            rd_ctrl_r;
   logic [2:0]            wr_ctrl_r;
   logic [1:0]            state_r;
   logic [DATA_WIDTH-1:0] dout_r;

   logic                  req_in_s;
   logic [1:0]            busy_in_s;
   logic [1:0]            state_s;
   logic                  req_rd_s;
   logic                  req_wr_s;
   logic [2:0]            off_s;
   logic [IDX_W-1:0]      idx_s;
   logic [3:0]            size_s;
   logic                  err_s;
   logic [63:0]           word_s;
   logic [63:0]           wr_mask_s;
   logic [63:0]           merged_s;
   logic                  commit_s;

   // Decode the live request pins (only meaningful while idle).
   always_comb begin
      req_in_s  = 1'b0;
      busy_in_s = CODE_WR;
      if ((bus.rd_ctrl != 3'b000) || (bus.wr_ctrl != 3'b000)) begin
         req_in_s = 1'b1;
      end else begin
         req_in_s = 1'b0;
      end
      if (bus.rd_ctrl != 3'b000) begin
         busy_in_s = CODE_RD;
      end else begin
         busy_in_s = CODE_WR;
      end
   end

   // Raise the busy code in the very cycle a request appears so the
   // requester never samples a stale 00; otherwise show the registered code.
   always_comb begin
      state_s = state_r;
      if ((fsm_r == ST_IDLE) && req_in_s) begin
         state_s = busy_in_s;
      end else begin
         state_s = state_r;
      end
   end

   assign bus.state = state_s;
   assign bus.dout  = dout_r;

   // Decode the captured beat: lane, word index, size and error conditions.
   always_comb begin
      req_rd_s = (rd_ctrl_r != 3'b000);
      req_wr_s = (wr_ctrl_r != 3'b000);
      off_s    = addr_r[2:0];
      // Low index bits only; the full-width range check below rejects
      // anything the truncated subtraction could misplace.
      idx_s    = addr_r[IDX_W+2:3] - BASE_ADDR[IDX_W+2:3];
      size_s   = 4'd0;
      if (req_rd_s) begin
         size_s = rd_size(rd_ctrl_r);
      end else begin
         size_s = wr_size(wr_ctrl_r);
      end
      err_s = 1'b0;
      if ((addr_r < BASE_ADDR) || (addr_r >= END_ADDR)) begin
         err_s = 1'b1;
      end else if (({1'b0, off_s} + size_s) > 4'd8) begin
         err_s = 1'b1;
      end else if (req_rd_s && req_wr_s) begin
         err_s = 1'b1;
      end else if (wr_ctrl_r > 3'b100) begin
         err_s = 1'b1;
      end else begin
         err_s = 1'b0;
      end
   end

   assign word_s    = mem_r[idx_s];
   assign wr_mask_s = lane_mask(size_s, off_s);
   assign merged_s  = (word_s & ~wr_mask_s) | ((din_r << {off_s, 3'b000}) & wr_mask_s);
   assign commit_s  = (fsm_r == ST_ACCESS) && (cnt_r == CNT_W'(0)) && req_wr_s && !err_s;

   // Beat sequencer: capture in IDLE, count latency in ACCESS, report in DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_r     <= ST_IDLE;
         cnt_r     <= CNT_W'(0);
         addr_r    <= '0;
         din_r     <= '0;
         rd_ctrl_r <= 3'b000;
         wr_ctrl_r <= 3'b000;
         state_r   <= CODE_OK;
         dout_r    <= '0;
      end else begin
         case (fsm_r)
            ST_IDLE: begin
               if (req_in_s) begin
                  addr_r    <= bus.addr;
                  din_r     <= bus.din;
                  rd_ctrl_r <= bus.rd_ctrl;
                  wr_ctrl_r <= bus.wr_ctrl;
                  cnt_r     <= CNT_LOAD;
                  state_r   <= busy_in_s;
                  fsm_r     <= ST_ACCESS;
               end else begin
                  state_r   <= CODE_OK;
                  dout_r    <= '0;
               end
            end
            ST_ACCESS: begin
               if (cnt_r == CNT_W'(0)) begin
                  fsm_r <= ST_DONE;
                  if (err_s) begin
                     state_r <= CODE_ERR;
                     dout_r  <= '0;
                  end else if (req_rd_s) begin
                     state_r <= CODE_OK;
                     dout_r  <= fmt_read(word_s, off_s, rd_ctrl_r);
                  end else begin
                     state_r <= CODE_OK;
                     dout_r  <= '0;
                  end
               end else begin
                  cnt_r <= cnt_r - CNT_W'(1);
               end
            end
            ST_DONE: begin
               fsm_r   <= ST_IDLE;
               state_r <= CODE_OK;
               dout_r  <= '0;
            end
            default: begin
               fsm_r   <= ST_IDLE;
               state_r <= CODE_OK;
               dout_r  <= '0;
            end
         endcase
      end
   end

   // RAM write port: byte-merged commit on the last ACCESS edge; contents
   // are deliberately not cleared by reset, and a reset edge blocks the commit.
   always_ff @(posedge clk) begin
      if (!rst && commit_s) begin
         mem_r[idx_s] <= merged_s;
      end
   end

endmodule

// File: tb/tb_dram_ctrl.sv
// Directed self-checking bench for dram_ctrl (LATENCY = 3).
module tb_dram_ctrl;

   localparam int LAT = 3;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   dram_ctrl_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) bus ();

   dram_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Runs one beat starting just after a rising edge. Checks the busy code
   // for LAT+1 cycles, the completion code and data, then one idle cycle.
   // With drop set, the request pins are cleared once the beat is captured.
   task automatic beat(input string tag, input logic [2:0] rd, input logic [2:0] wr,
                       input logic [63:0] a, input logic [63:0] d,
                       input logic [1:0] busy, input logic [1:0] fin,
                       input logic [63:0] exp, input bit drop);
      bus.addr    = a;
      bus.din     = d;
      bus.rd_ctrl = rd;
      bus.wr_ctrl = wr;
      for (int i = 0; i < LAT + 1; i++) begin
         @(negedge clk);
         check_val({tag, "_busy"}, {62'd0, bus.state}, {62'd0, busy});
         @(posedge clk);
         #1;
         if (drop) begin
            bus.rd_ctrl = 3'b000;
            bus.wr_ctrl = 3'b000;
            bus.addr    = 64'h0000_0000_0000_DEAD;
         end
      end
      @(negedge clk);
      check_val({tag, "_done"}, {62'd0, bus.state}, {62'd0, fin});
      check_val({tag, "_dout"}, bus.dout, exp);
      bus.rd_ctrl = 3'b000;
      bus.wr_ctrl = 3'b000;
      @(posedge clk);
      #1;
      @(negedge clk);
      check_val({tag, "_idle"}, {62'd0, bus.state}, 64'd0);
      check_val({tag, "_idle_dout"}, bus.dout, 64'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst         = 1'b1;
      bus.addr    = 64'd0;
      bus.din     = 64'd0;
      bus.rd_ctrl = 3'b000;
      bus.wr_ctrl = 3'b000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("reset_state", {62'd0, bus.state}, 64'd0);
      check_val("reset_dout", bus.dout, 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Full word write then read back.
      beat("sd10", 3'b000, 3'b100, 64'h8000_0010, 64'h1122_3344_5566_7788, 2'b10, 2'b00, 64'd0, 1'b0);
      beat("ld10", 3'b110, 3'b000, 64'h8000_0010, 64'd0, 2'b01, 2'b00, 64'h1122_3344_5566_7788, 1'b0);

      // Byte merge; upper din bytes must be ignored.
      beat("sb13", 3'b000, 3'b001, 64'h8000_0013, 64'hAAAA_AAAA_AAAA_AAF0, 2'b10, 2'b00, 64'd0, 1'b0);
      beat("lb13", 3'b001, 3'b000, 64'h8000_0013, 64'd0, 2'b01, 2'b00, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0);
      beat("lbu13", 3'b010, 3'b000, 64'h8000_0013, 64'd0, 2'b01, 2'b00, 64'h0000_0000_0000_00F0, 1'b0);
      beat("ld10b", 3'b110, 3'b000, 64'h8000_0010, 64'd0, 2'b01, 2'b00, 64'h1122_3344_F066_7788, 1'b0);

      // Halfword into the top lanes, then halfword/word reads both extensions.
      beat("sh16", 3'b000, 3'b010, 64'h8000_0016, 64'h5555_5555_5555_8001, 2'b10, 2'b00, 64'd0, 1'b0);
      beat("lh16", 3'b011, 3'b000, 64'h8000_0016, 64'd0, 2'b01, 2'b00, 64'hFFFF_FFFF_FFFF_8001, 1'b0);
      beat("lhu16", 3'b100, 3'b000, 64'h8000_0016, 64'd0, 2'b01, 2'b00, 64'h0000_0000_0000_8001, 1'b0);
      beat("lw14", 3'b101, 3'b000, 64'h8000_0014, 64'd0, 2'b01, 2'b00, 64'hFFFF_FFFF_8001_3344, 1'b0);
      beat("lwu14", 3'b111, 3'b000, 64'h8000_0014, 64'd0, 2'b01, 2'b00, 64'h0000_0000_8001_3344, 1'b0);

      // Back-to-back reads with rd_ctrl held; address changes after DONE.
      beat("sd00", 3'b000, 3'b100, 64'h8000_0000, 64'hA0A1_A2A3_A4A5_A6A7, 2'b10, 2'b00, 64'd0, 1'b0);
      beat("sd08", 3'b000, 3'b100, 64'h8000_0008, 64'hB0B1_B2B3_B4B5_B6B7, 2'b10, 2'b00, 64'd0, 1'b0);
      bus.addr    = 64'h8000_0000;
      bus.rd_ctrl = 3'b110;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (c == 4) begin
            check_val("b2b_done0", {62'd0, bus.state}, 64'd0);
            check_val("b2b_dout0", bus.dout, 64'hA0A1_A2A3_A4A5_A6A7);
            bus.addr = 64'h8000_0008;
         end else if (c == 9) begin
            check_val("b2b_done1", {62'd0, bus.state}, 64'd0);
            check_val("b2b_dout1", bus.dout, 64'hB0B1_B2B3_B4B5_B6B7);
            bus.rd_ctrl = 3'b000;
         end else begin
            check_val("b2b_busy", {62'd0, bus.state}, 64'd1);
         end
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      check_val("b2b_idle", {62'd0, bus.state}, 64'd0);
      @(posedge clk);
      #1;

      // Error beats: state 11 on the done cycle, dout 0, RAM untouched.
      beat("lw_cross", 3'b101, 3'b000, 64'h8000_0006, 64'd0, 2'b01, 2'b11, 64'd0, 1'b0);
      beat("ld_below", 3'b110, 3'b000, 64'h7FFF_FFF8, 64'd0, 2'b01, 2'b11, 64'd0, 1'b0);
      beat("rd_wr", 3'b110, 3'b100, 64'h8000_0010, 64'hCAFE_CAFE_CAFE_CAFE, 2'b01, 2'b11, 64'd0, 1'b0);
      beat("wr_ill", 3'b000, 3'b101, 64'h8000_0010, 64'hCAFE_CAFE_CAFE_CAFE, 2'b10, 2'b11, 64'd0, 1'b0);
      beat("sh_cross", 3'b000, 3'b010, 64'h8000_0017, 64'hCAFE_CAFE_CAFE_CAFE, 2'b10, 2'b11, 64'd0, 1'b0);
      beat("ld_end", 3'b110, 3'b000, 64'h8000_8000, 64'd0, 2'b01, 2'b11, 64'd0, 1'b0);
      beat("sd_hi4g", 3'b000, 3'b100, 64'h0000_0001_8000_0010, 64'hCAFE_CAFE_CAFE_CAFE, 2'b10, 2'b11, 64'd0, 1'b0);
      beat("ld10_kept", 3'b110, 3'b000, 64'h8000_0010, 64'd0, 2'b01, 2'b00, 64'h8001_3344_F066_7788, 1'b0);

      // Highest legal word.
      beat("sd_top", 3'b000, 3'b100, 64'h8000_7FF8, 64'h5A5A_0F0F_1234_9876, 2'b10, 2'b00, 64'd0, 1'b0);
      beat("ld_top", 3'b110, 3'b000, 64'h8000_7FF8, 64'd0, 2'b01, 2'b00, 64'h5A5A_0F0F_1234_9876, 1'b0);

      // Reset during ACCESS abandons the write.
      beat("sd20", 3'b000, 3'b100, 64'h8000_0020, 64'h0123_4567_89AB_CDEF, 2'b10, 2'b00, 64'd0, 1'b0);
      bus.addr    = 64'h8000_0020;
      bus.din     = 64'hFFFF_EEEE_DDDD_CCCC;
      bus.wr_ctrl = 3'b100;
      @(posedge clk);
      #1;
      @(negedge clk);
      check_val("rst_mid_busy", {62'd0, bus.state}, 64'd2);
      rst         = 1'b1;
      bus.wr_ctrl = 3'b000;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_val("rst_mid_state", {62'd0, bus.state}, 64'd0);
      check_val("rst_mid_dout", bus.dout, 64'd0);
      @(posedge clk);
      #1;
      beat("ld20", 3'b110, 3'b000, 64'h8000_0020, 64'd0, 2'b01, 2'b00, 64'h0123_4567_89AB_CDEF, 1'b0);

      // Request removed mid-ACCESS still completes with captured values.
      beat("ld_drop", 3'b110, 3'b000, 64'h8000_0010, 64'd0, 2'b01, 2'b00, 64'h8001_3344_F066_7788, 1'b1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
